// File: rtl/ov5640_sccb_wr.sv
// SCCB (I2C-compatible) 3-phase write master for OV5640 register bring-up.
// One accepted request -> START, 4 bytes (ID, addr hi, addr lo, data) each with ACK slot, STOP.
module ov5640_sccb_wr #(
   parameter logic [7:0]  DEV_ADDR = 8'h78,
   parameter int unsigned DIV_QTR  = 50
) (
   input  logic        sys_clk,
   input  logic        sys_rst,
   input  logic        cfg_start,
   input  logic [23:0] cfg_data,
   output logic        cfg_end,
   output logic        busy,
   output logic        ack_err,
   output logic        sccb_scl,
   output logic        sccb_sda_oe,
   input  logic        sccb_sda_i
);

   localparam logic [9:0] QMAX = 10'(DIV_QTR - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      BYTE,
      ACK,
      STOP
   } state_t;

   state_t      state_reg,   state_next;
   logic [9:0]  qcnt_reg,    qcnt_next;
   logic [1:0]  qtr_reg,     qtr_next;
   logic [2:0]  bit_reg,     bit_next;
   logic [1:0]  byte_reg,    byte_next;
   logic [31:0] shift_reg,   shift_next;
   logic        nack_reg,    nack_next;
   logic        cfg_end_reg, cfg_end_next;
   logic        busy_reg,    busy_next;
   logic        ack_err_reg, ack_err_next;
   logic        scl_reg,     scl_next;
   logic        sda_oe_reg,  sda_oe_next;

   logic wrap;
   logic last_q;

   assign wrap   = (qcnt_reg == QMAX);
   assign last_q = wrap && (qtr_reg == 2'd3);

   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state_reg   <= IDLE;
         qcnt_reg    <= '0;
         qtr_reg     <= '0;
         bit_reg     <= '0;
         byte_reg    <= '0;
         shift_reg   <= '0;
         nack_reg    <= 1'b0;
         cfg_end_reg <= 1'b0;
         busy_reg    <= 1'b0;
         ack_err_reg <= 1'b0;
         scl_reg     <= 1'b1;
         sda_oe_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         qcnt_reg    <= qcnt_next;
         qtr_reg     <= qtr_next;
         bit_reg     <= bit_next;
         byte_reg    <= byte_next;
         shift_reg   <= shift_next;
         nack_reg    <= nack_next;
         cfg_end_reg <= cfg_end_next;
         busy_reg    <= busy_next;
         ack_err_reg <= ack_err_next;
         scl_reg     <= scl_next;
         sda_oe_reg  <= sda_oe_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      qcnt_next    = qcnt_reg;
      qtr_next     = qtr_reg;
      bit_next     = bit_reg;
      byte_next    = byte_reg;
      shift_next   = shift_reg;
      nack_next    = nack_reg;
      cfg_end_next = 1'b0;
      busy_next    = busy_reg;
      ack_err_next = ack_err_reg;
      scl_next     = 1'b1;
      sda_oe_next  = 1'b0;

      if (state_reg != IDLE) begin
         qcnt_next = wrap ? 10'd0 : qcnt_reg + 10'd1;
         if (wrap) begin
            qtr_next = qtr_reg + 2'd1;
         end
      end

      case (state_reg)
         IDLE: begin
            // The cfg_end cycle still reads IDLE, so it is masked explicitly.
            if (cfg_start && !cfg_end_reg) begin
               state_next   = START;
               shift_next   = {DEV_ADDR, cfg_data};
               busy_next    = 1'b1;
               nack_next    = 1'b0;
               ack_err_next = 1'b0;
               qcnt_next    = '0;
               qtr_next     = '0;
               bit_next     = '0;
               byte_next    = '0;
            end
         end
         START: begin
            if (last_q) begin
               state_next = BYTE;
            end
         end
         BYTE: begin
            if (last_q) begin
               shift_next = {shift_reg[30:0], 1'b0};
               if (bit_reg == 3'd7) begin
                  bit_next   = '0;
                  state_next = ACK;
               end else begin
                  bit_next = bit_reg + 3'd1;
               end
            end
         end
         ACK: begin
            // Slave's 9th bit is taken at the end of the SCL-high window; NACK never aborts.
            if (wrap && (qtr_reg == 2'd2)) begin
               nack_next = nack_reg | sccb_sda_i;
            end
            if (last_q) begin
               if (byte_reg == 2'd3) begin
                  state_next = STOP;
               end else begin
                  byte_next  = byte_reg + 2'd1;
                  state_next = BYTE;
               end
            end
         end
         STOP: begin
            if (last_q) begin
               state_next   = IDLE;
               cfg_end_next = 1'b1;
               busy_next    = 1'b0;
               ack_err_next = nack_reg;
            end
         end
         default: state_next = IDLE;
      endcase

      // Pins are decoded from the upcoming state so they change exactly on quarter boundaries.
      case (state_next)
         START: begin
            scl_next    = (qtr_next != 2'd3);
            sda_oe_next = qtr_next[1];
         end
         BYTE: begin
            scl_next    = (qtr_next == 2'd1) || (qtr_next == 2'd2);
            sda_oe_next = ~shift_next[31];
         end
         ACK: begin
            scl_next    = (qtr_next == 2'd1) || (qtr_next == 2'd2);
            sda_oe_next = 1'b0;
         end
         STOP: begin
            scl_next    = (qtr_next != 2'd0);
            sda_oe_next = ~qtr_next[1];
         end
         default: begin
            scl_next    = 1'b1;
            sda_oe_next = 1'b0;
         end
      endcase
   end

   assign cfg_end     = cfg_end_reg;
   assign busy        = busy_reg;
   assign ack_err     = ack_err_reg;
   assign sccb_scl    = scl_reg;
   assign sccb_sda_oe = sda_oe_reg;

endmodule

// File: doc/ov5640_sccb_wr.md
Name: ov5640_sccb_wr

Overview:
- SCCB (I2C-compatible) write master for OV5640 sensor bring-up.
- Responder side of the register-sequencer handshake: accepts cfg_start with a 24-bit {reg_addr[15:0], reg_val[7:0]} word and performs one 4-phase SCCB write (ID, addr hi, addr lo, data).
- Returns a one-cycle cfg_end when the bus is back to idle.
- Drives the sensor SIOC/SIOD pins through an open-drain SDA model.

Parameters:
- DEV_ADDR, 8'h78: SCCB write ID byte sent first; R/W bit is 0.
- DIV_QTR, 50: sys_clk cycles per SCL quarter-period. SCL period = 4*DIV_QTR (250 kHz at 50 MHz). Legal range 2..1023.

Ports:
- sys_clk  in  1  system clock
- sys_rst  in  1  synchronous reset, active-high
- cfg_start  in  1  single-cycle request; sampled only when idle
- cfg_data  in  24  {reg_addr[15:0], reg_val[7:0]}; latched on accepted cfg_start
- cfg_end  out  1  one-cycle pulse, transaction finished
- busy  out  1  high from the cycle after acceptance until cfg_end
- ack_err  out  1  valid with cfg_end; 1 if any of the 4 ACK slots sampled high
- sccb_scl  out  1  SIOC, push-pull
- sccb_sda_oe  out  1  1 = pull SIOD low, 0 = release (external pull-up = high)
- sccb_sda_i  in  1  SIOD pin readback

Behaviour:
- Reset values (registered, applied on the next edge with sys_rst=1): sccb_scl=1, sccb_sda_oe=0, cfg_end=0, busy=0, ack_err=0, state=IDLE, counters=0.
- Reset mid-transaction aborts immediately and releases the bus. No STOP is generated; this is acceptable.
- Timing base: quarter counter 0..DIV_QTR-1. Quarter index q (0..3) advances when the counter wraps. All pin changes occur at quarter boundaries.
- States: IDLE -> START -> BYTE -> ACK -> (BYTE | STOP) -> IDLE.
  - IDLE: scl=1, sda released. cfg_start=1 latches cfg_data into a shift word {DEV_ADDR, cfg_data}, sets busy, clears the internal NACK flag, and moves to START.
  - START: q0/q1 scl=1, sda released; q2 sda low (SCL high); q3 scl low.
  - BYTE: 8 bits, MSB first, byte index 0..3. Per bit: q0 scl low and SDA set (oe = ~bit); q1/q2 scl high; q3 scl low.
  - ACK: sda released for all 4 quarters; scl low/high/high/low. sccb_sda_i is sampled on the last cycle of q2 and ORed into the NACK flag.
  - ACK exit: after ACK of byte 3, go to STOP; otherwise go to the next byte.
  - NACK does not abort. SCCB treats the 9th bit as don't-care; all 4 bytes are always sent.
  - STOP: q0 scl low, sda low; q1 scl high, sda low; q2 sda released (SCL high); q3 idle.
- STOP exit: go to IDLE and, in the same edge, pulse cfg_end=1, drop busy=0, and set ack_err=NACK flag. ack_err holds until the next acceptance, where it clears.
- Latency: quarters = 4 (START) + 4*9*4 (bytes with ACK) + 4 (STOP) = 152. cfg_end is high exactly 152*DIV_QTR+1 cycles after the cfg_start cycle (7601 at default).
- cfg_start while busy, or in the cfg_end cycle, is ignored, and cfg_data is not relatched. cfg_start in the cycle after cfg_end is accepted.
- Simultaneous sys_rst and cfg_start: reset wins.
- cfg_data may change freely after acceptance.
- SDA changes only while SCL is low, except for START and STOP edges.

Test Plan:
- Single write, cfg_data=24'h310311, slave ACKs (sda_i=0 in ACK slots).
  - Bus decoder sees START, bytes 78,31,03,11, STOP.
  - cfg_end on cycle 7601; ack_err=0; busy high cycles 1..7600.
- Write 24'h3036B8 with sda_i=1 only during the 3rd ACK slot.
  - All 4 bytes are still transmitted.
  - ack_err=1 with cfg_end; the next transaction with ACKs gives ack_err=0.
- cfg_start pulsed at cycle 100 of a transaction with cfg_data=24'hFFFFFF.
  - Ignored; bytes on the bus still match the first word; exactly one cfg_end.
- cfg_start asserted in the cfg_end cycle and again one cycle later.
  - First pulse is ignored, second is accepted.
  - SCL/SDA stay high between STOP and the new START; the second cfg_end arrives 7601 cycles after acceptance.
- sys_rst asserted during byte 2.
  - Next cycle: scl=1, sda_oe=0, busy=0, cfg_end=0, ack_err=0.
  - A following cfg_start completes a normal transaction.
- DIV_QTR=2, cfg_data=24'h300882.
  - SCL period 8 cycles; cfg_end at cycle 305; decoded bytes 78,30,08,82.
